// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width helper and error-flag type for the parametrised FIFO
package fifo_pkg;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port register array, synchronous write, registered read
//   clk_i/rst_i   clock, async active-high reset (clears only the read register)
//   we_i/waddr_i/wdata_i  write port
//   re_i/raddr_i/rdata_o  read port, rdata_o updates one clock after re_i and holds otherwise
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[raddr_i];
endmodule

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised single-clock FIFO with count, almost flags and sticky errors
//   clk, rst              clock, async active-high reset
//   wr, wr_data, wr_en    write request / data / accepted strobe
//   rd, rd_en             read request / accepted strobe
//   rd_data, rd_valid     registered read word, valid one clock after rd_en
//   wr_ptr, rd_ptr        pointers with wrap bit in the MSB
//   count, emp, full, almost_full, almost_empty   occupancy status
//   overflow, underflow, clr_err                  sticky rejection flags and their clear
module fifo_ctrl_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd,
  input  logic                       clr_err,
  output logic                       wr_en,
  output logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [ptr_w(DEPTH)-1:0]    wr_ptr,
  output logic [ptr_w(DEPTH)-1:0]    rd_ptr,
  output logic [ptr_w(DEPTH)-1:0]    count,
  output logic                       emp,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);
  localparam logic [PW-1:0] AF  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE  = PW'(AE_LEVEL);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic          rd_valid_q;
  err_t          err_q, err_d;
  // Empty/full come from the pointers; the wrap bit distinguishes a full lap from empty.
  assign emp  = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
  always_comb begin
    rd_en    = rd & ~emp;
    // A write while full only fits if the same-cycle read frees a slot.
    wr_en    = wr & (~full | rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
    count_d  = (wr_en & ~rd_en) ? count_q + ONE :
               (rd_en & ~wr_en) ? count_q - ONE : count_q;
    // A fresh error in the clearing cycle must survive the clear.
    err_d.overflow  = (wr & ~wr_en) | (err_q.overflow & ~clr_err);
    err_d.underflow = (rd & ~rd_en) | (err_q.underflow & ~clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_en;
      err_q      <= err_d;
    end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );
  assign wr_ptr       = wr_ptr_q;
  assign rd_ptr       = rd_ptr_q;
  assign count        = count_q;
  assign rd_valid     = rd_valid_q;
  assign almost_full  = count_q >= AF;
  assign almost_empty = count_q <= AE;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;
endmodule
